// File: rtl/seqdet_pkg.sv
// seqdet_pkg: shared types and helpers for the parametrised sequence detector.
// FSM state encoding, the length-to-mask helper and the legal pattern-length
// range used when validating a runtime configuration load.
package seqdet_pkg;

    // S_LOCK is only reachable when SEQDET_LOCK_EN is defined.
    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_CFG  = 2'd1,
        S_LOCK = 2'd2
    } state_t;

    // Shortest legal runtime pattern length.
    localparam int unsigned LEN_MIN   = 1;
    // Widest pattern any instance may be built for.
    localparam int unsigned PAT_W_MAX = 32;

    // Mask with the low 'len' bits set; callers truncate to their own width.
    function automatic logic [PAT_W_MAX-1:0] len_to_mask(input int unsigned len);
        logic [PAT_W_MAX-1:0] m;
        for (int unsigned i = 0; i < PAT_W_MAX; i++) begin
            m[i] = (i < len);
        end
        return m;
    endfunction

    // A length is usable if it lies in LEN_MIN..max_len.
    function automatic logic len_is_legal(input int unsigned len, input int unsigned max_len);
        return (len >= LEN_MIN) && (len <= max_len);
    endfunction

endpackage

// File: rtl/seqdet_shift_cmp.sv
// seqdet_shift_cmp: history shift register, fill counter and masked compare.
// match_next is combinational and reports that the bit being sampled this
// cycle completes the pattern; the caller registers it.
module seqdet_shift_cmp
    import seqdet_pkg::*;
#(
    parameter int PAT_W = 16,
    parameter int LW    = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             sample,
    input  logic             x,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LW-1:0]    len,
    input  logic             overlap,
    output logic             match_next
);

    logic [PAT_W-1:0] history_q, history_d;
    logic [PAT_W-1:0] history_shift;
    logic [PAT_W-1:0] mask;
    logic [LW-1:0]    fill_q, fill_d;
    logic [LW-1:0]    fill_inc;

    assign mask = PAT_W'(len_to_mask(32'(len)));

    // Candidate history/fill after this bit, the masked compare, and the update.
    always_comb begin
        history_shift = {history_q[PAT_W-2:0], x};
        fill_inc      = (fill_q == LW'(PAT_W)) ? fill_q : fill_q + LW'(1);
        match_next    = sample && (fill_inc >= len) &&
                        (((history_shift ^ pattern) & mask) == '0);
        history_d     = history_q;
        fill_d        = fill_q;
        if (clr) begin
            history_d = '0;
            fill_d    = '0;
        end else if (sample) begin
            history_d = history_shift;
            // Without overlap the next match must be built from fresh bits.
            fill_d    = (match_next && !overlap) ? '0 : fill_inc;
        end
    end

    // History and fill registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            history_q <= '0;
            fill_q    <= '0;
        end else begin
            history_q <= history_d;
            fill_q    <= fill_d;
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// seq_detector_param: runtime-configurable serial bit-pattern detector.
// Holds the control FSM, the active/pending configuration and the saturating
// match counter; the bit history and compare live in seqdet_shift_cmp.
// Optional feature macro: SEQDET_LOCK_EN -- after the first match the detector
// locks with z held high until a legal reconfiguration or reset.
module seq_detector_param
    import seqdet_pkg::*;
#(
    parameter int          PAT_W       = 16,
    parameter int          CNT_W       = 8,
    parameter logic [31:0] RST_PATTERN = 32'b10011,
    parameter int          RST_LEN     = 5
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         x,
    input  logic                         x_valid,
    input  logic                         cfg_load,
    input  logic [PAT_W-1:0]             cfg_pattern,
    input  logic [$clog2(PAT_W+1)-1:0]   cfg_len,
    input  logic                         cfg_overlap,
    input  logic                         cnt_clr,
    output logic                         z,
    output logic                         cfg_err,
    output logic [CNT_W-1:0]             match_cnt
);

    localparam int LW = $clog2(PAT_W + 1);

    state_t           state_q, state_d;
    logic [PAT_W-1:0] pattern_q, pattern_d;
    logic [LW-1:0]    len_q, len_d;
    logic             overlap_q, overlap_d;
    logic [PAT_W-1:0] pend_pattern_q, pend_pattern_d;
    logic [LW-1:0]    pend_len_q, pend_len_d;
    logic             pend_overlap_q, pend_overlap_d;
    logic             z_q, z_d;
    logic             cfg_err_q, cfg_err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic len_ok;
    logic load_window;
    logic load_accept;
    logic load_reject;
    logic sample;
    logic hist_clr;
    logic match_next;

    // A load is only considered outside the reconfiguration bubble; a load
    // always takes the cycle, so any bit offered alongside it is dropped.
    assign len_ok      = len_is_legal(32'(cfg_len), unsigned'(PAT_W));
    assign load_window = (state_q != S_CFG);
    assign load_accept = cfg_load && len_ok && load_window;
    assign load_reject = cfg_load && !len_ok && load_window;
    assign sample      = x_valid && !cfg_load && (state_q == S_RUN);
    assign hist_clr    = (state_q == S_CFG);

    seqdet_shift_cmp #(
        .PAT_W (PAT_W),
        .LW    (LW)
    ) u_shift_cmp (
        .clk        (clk),
        .reset      (reset),
        .clr        (hist_clr),
        .sample     (sample),
        .x          (x),
        .pattern    (pattern_q),
        .len        (len_q),
        .overlap    (overlap_q),
        .match_next (match_next)
    );

    // Next-state, configuration capture/commit and output pulse logic.
    always_comb begin
        state_d        = state_q;
        z_d            = 1'b0;
        cfg_err_d      = load_reject;
        pattern_d      = pattern_q;
        len_d          = len_q;
        overlap_d      = overlap_q;
        pend_pattern_d = pend_pattern_q;
        pend_len_d     = pend_len_q;
        pend_overlap_d = pend_overlap_q;

        if (load_accept) begin
            pend_pattern_d = cfg_pattern;
            pend_len_d     = cfg_len;
            pend_overlap_d = cfg_overlap;
        end

        case (state_q)
            S_RUN: begin
                if (load_accept) begin
                    state_d = S_CFG;
                end else begin
                    z_d = match_next;
`ifdef SEQDET_LOCK_EN
                    if (match_next) begin
                        state_d = S_LOCK;
                    end
`endif
                end
            end
            S_CFG: begin
                pattern_d = pend_pattern_q;
                len_d     = pend_len_q;
                overlap_d = pend_overlap_q;
                state_d   = S_RUN;
            end
`ifdef SEQDET_LOCK_EN
            S_LOCK: begin
                if (load_accept) begin
                    state_d = S_CFG;
                end else begin
                    z_d = 1'b1;
                end
            end
`endif
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    // Saturating match counter; a clear beats a simultaneous increment.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (match_next && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State, configuration, output and counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= S_RUN;
            pattern_q      <= RST_PATTERN[PAT_W-1:0];
            len_q          <= LW'(RST_LEN);
            overlap_q      <= 1'b0;
            pend_pattern_q <= RST_PATTERN[PAT_W-1:0];
            pend_len_q     <= LW'(RST_LEN);
            pend_overlap_q <= 1'b0;
            z_q            <= 1'b0;
            cfg_err_q      <= 1'b0;
            cnt_q          <= '0;
        end else begin
            state_q        <= state_d;
            pattern_q      <= pattern_d;
            len_q          <= len_d;
            overlap_q      <= overlap_d;
            pend_pattern_q <= pend_pattern_d;
            pend_len_q     <= pend_len_d;
            pend_overlap_q <= pend_overlap_d;
            z_q            <= z_d;
            cfg_err_q      <= cfg_err_d;
            cnt_q          <= cnt_d;
        end
    end

    assign z         = z_q;
    assign cfg_err   = cfg_err_q;
    assign match_cnt = cnt_q;

endmodule
